life_ctrl: RTL
==============

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 SHALL have parameter GEN_W, default 16, meaning width of generation counters.
REQ-002 SHALL have parameter PERIOD_W, default 24, meaning width of step-period counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port op_valid  input  1  host operation request.
REQ-006 SHALL have port op_ready  output  1  high only in IDLE; op accepted when op_valid&&op_ready.
REQ-007 SHALL have port op_code  input  2  00 CLEAR, 01 WRITE, 10 READ, 11 RUN.
REQ-008 SHALL have port op_x / op_y  input  `N_PX_BITS / `N_PY_BITS  cell address.
REQ-009 SHALL have port op_data  input  `PE_STATE_BITS  WRITE value.
REQ-010 SHALL have port op_gens  input  GEN_W  RUN generation count; 0 = run until stop.
REQ-011 SHALL have port period  input  PERIOD_W  cycles between STEPs; sampled at RUN accept.
REQ-012 SHALL have port stop  input  1  abort RUN.
REQ-013 SHALL have port rd_valid / rd_data  output  1 / `PE_STATE_BITS  READ result pulse.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of every op.
REQ-015 SHALL have port gen_count  output  GEN_W  generations stepped since last CLEAR.
REQ-016 SHALL have port pe_cmd  output  `PE_CMD_BITS  command to array, `PE_CMD_* codes.
REQ-017 SHALL have ports pe_state_o output / pe_state_i input  `PE_STATE_BITS  array write data / OR-ed read data.
REQ-018 SHALL have port pe_active  input  1  array reports at least one cell changed.
REQ-019 SHALL have ports pe_adr_x / pe_adr_y  output  `N_PX_BITS / `N_PY_BITS  array address.

Function
REQ-020 SHALL implement states IDLE, CLEAR, WRITE, READ, CAPTURE, WAIT, STEP, SETTLE.
REQ-021 SHALL drive pe_cmd=`PE_CMD_NOP in every state except CLEAR, WRITE, READ, STEP.
REQ-022 SHALL register op_x/op_y/op_data/op_gens/period at accept; pe_adr_*/pe_state_o hold registered values.
REQ-023 CLEAR: one cycle pe_cmd=`PE_CMD_RESET, gen_count<=0, done, -> IDLE.
REQ-024 WRITE: one cycle pe_cmd=`PE_CMD_WRITE with address/data valid, done, -> IDLE.
REQ-025 READ: one cycle pe_cmd=`PE_CMD_READ; CAPTURE next cycle registers pe_state_i; rd_valid and done pulse the cycle after CAPTURE (accept-to-rd_valid latency 3 cycles).
REQ-026 RUN: WAIT counts max(period,1) cycles, then STEP one cycle pe_cmd=`PE_CMD_STEP, then SETTLE one cycle.
REQ-027 In STEP, gen_count SHALL increment, wrapping modulo 2^GEN_W; remaining count decrements if op_gens!=0.
REQ-028 SETTLE SHALL go to IDLE with done when remaining count reaches 0, else to WAIT.
REQ-029 stop high in WAIT or SETTLE SHALL go IDLE next cycle with done, no further STEP; stop in STEP lets that STEP complete.
REQ-030 stop outside RUN SHALL be ignored; op_valid while busy SHALL not be accepted.
REQ-031 rd_data SHALL hold last captured value until next READ.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, pe_cmd=`PE_CMD_NOP, all counters, address, data, rd_valid, done to 0, op_ready to 0 while low.
REQ-033 Reset mid-RUN SHALL abandon the run with no done pulse; op_ready rises first clock after rst_n deasserts.

Configuration
REQ-034 With LIFE_CTRL_AUTOSTOP_EN defined, SETTLE SHALL sample pe_active and, if 0, end the run (IDLE, done) regardless of remaining count.
REQ-035 Without LIFE_CTRL_AUTOSTOP_EN, pe_active SHALL be ignored and runs end only by count or stop.

Verification
REQ-036 CLEAR after 5 gens -> single pe_cmd=RESET cycle, gen_count=0, done one cycle.
REQ-037 WRITE x=3,y=7,data=1 then READ x=3,y=7 with pe_state_i=1 -> rd_valid 3 cycles after accept, rd_data=1.
REQ-038 RUN op_gens=4, period=10 -> exactly 4 STEP pulses spaced 12 cycles, gen_count+=4, done once.
REQ-039 RUN op_gens=0, period=0, stop after 3rd STEP -> no 4th STEP, done next cycle, gen_count=3.
REQ-040 AUTOSTOP_EN build, RUN op_gens=100, pe_active=0 after 2nd STEP -> run ends after 2 gens; non-EN build runs 100.
REQ-041 rst_n low in WAIT -> pe_cmd=NOP, gen_count=0 asynchronously, no done.

Source files
------------

// File: rtl/life_ctrl.sv
// Sequencer for a cellular-automaton PE array: host CLEAR/WRITE/READ/RUN ops, paced STEP generation.
// Optional LIFE_CTRL_AUTOSTOP_EN: end a run early once the array reports no cell changed.

`ifndef N_PX_BITS
`define N_PX_BITS 4
`endif
`ifndef N_PY_BITS
`define N_PY_BITS 4
`endif
`ifndef PE_STATE_BITS
`define PE_STATE_BITS 1
`endif
`ifndef PE_CMD_BITS
`define PE_CMD_BITS 3
`endif
`ifndef PE_CMD_NOP
`define PE_CMD_NOP 3'd0
`endif
`ifndef PE_CMD_RESET
`define PE_CMD_RESET 3'd1
`endif
`ifndef PE_CMD_WRITE
`define PE_CMD_WRITE 3'd2
`endif
`ifndef PE_CMD_READ
`define PE_CMD_READ 3'd3
`endif
`ifndef PE_CMD_STEP
`define PE_CMD_STEP 3'd4
`endif

module life_ctrl #(
    parameter int GEN_W    = 16,
    parameter int PERIOD_W = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [1:0]                 op_code,
    input  logic [`N_PX_BITS-1:0]      op_x,
    input  logic [`N_PY_BITS-1:0]      op_y,
    input  logic [`PE_STATE_BITS-1:0]  op_data,
    input  logic [GEN_W-1:0]           op_gens,
    input  logic [PERIOD_W-1:0]        period,
    input  logic                       stop,
    output logic                       rd_valid,
    output logic [`PE_STATE_BITS-1:0]  rd_data,
    output logic                       done,
    output logic [GEN_W-1:0]           gen_count,
    output logic [`PE_CMD_BITS-1:0]    pe_cmd,
    output logic [`PE_STATE_BITS-1:0]  pe_state_o,
    input  logic [`PE_STATE_BITS-1:0]  pe_state_i,
    input  logic                       pe_active,
    output logic [`N_PX_BITS-1:0]      pe_adr_x,
    output logic [`N_PY_BITS-1:0]      pe_adr_y
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, WRITE, READ, CAPTURE, WAIT, STEP, SETTLE
    } state_t;

    state_t                      state_reg, state_next;
    logic                        ready_en_reg;
    logic [`N_PX_BITS-1:0]       x_reg;
    logic [`N_PY_BITS-1:0]       y_reg;
    logic [`PE_STATE_BITS-1:0]   data_reg;
    logic [`PE_STATE_BITS-1:0]   rd_data_reg;
    logic [GEN_W-1:0]            remaining_reg;
    logic [GEN_W-1:0]            gen_count_reg;
    logic                        forever_reg;
    logic [PERIOD_W-1:0]         period_reg;
    logic [PERIOD_W-1:0]         wait_cnt_reg;
    logic                        rd_valid_reg;
    logic                        done_reg;
    logic                        accept;
    logic                        wait_last;
    logic                        run_last;
    logic                        auto_end;
    logic [PERIOD_W-1:0]         period_eff;

    assign op_ready   = ready_en_reg && (state_reg == IDLE);
    assign accept     = op_valid && op_ready;
    assign period_eff = (period_reg == '0) ? PERIOD_W'(1) : period_reg;
    assign wait_last  = (wait_cnt_reg >= period_eff - PERIOD_W'(1));
    assign run_last   = !forever_reg && (remaining_reg == '0);

`ifdef LIFE_CTRL_AUTOSTOP_EN
    assign auto_end = !pe_active;
`else
    logic unused_pe_active;
    assign unused_pe_active = pe_active;
    assign auto_end         = 1'b0;
`endif

    assign pe_adr_x   = x_reg;
    assign pe_adr_y   = y_reg;
    assign pe_state_o = data_reg;
    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign done       = done_reg;
    assign gen_count  = gen_count_reg;

    always_comb begin
        state_next = state_reg;
        pe_cmd     = `PE_CMD_NOP;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (op_code)
                        2'b00:   state_next = CLEAR;
                        2'b01:   state_next = WRITE;
                        2'b10:   state_next = READ;
                        default: state_next = WAIT;
                    endcase
                end
            end
            CLEAR: begin
                pe_cmd     = `PE_CMD_RESET;
                state_next = IDLE;
            end
            WRITE: begin
                pe_cmd     = `PE_CMD_WRITE;
                state_next = IDLE;
            end
            READ: begin
                pe_cmd     = `PE_CMD_READ;
                state_next = CAPTURE;
            end
            CAPTURE: state_next = IDLE;
            WAIT: begin
                if (stop)
                    state_next = IDLE;
                else if (wait_last)
                    state_next = STEP;
            end
            // stop is deliberately not looked at here: a STEP already issued always completes
            STEP: begin
                pe_cmd     = `PE_CMD_STEP;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (stop || run_last || auto_end)
                    state_next = IDLE;
                else
                    state_next = WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_en_reg  <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            data_reg      <= '0;
            rd_data_reg   <= '0;
            remaining_reg <= '0;
            gen_count_reg <= '0;
            forever_reg   <= 1'b0;
            period_reg    <= '0;
            wait_cnt_reg  <= '0;
            rd_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ready_en_reg <= 1'b1;
            rd_valid_reg <= (state_reg == CAPTURE);
            done_reg     <= (state_reg != IDLE) && (state_next == IDLE);
            if (accept) begin
                x_reg         <= op_x;
                y_reg         <= op_y;
                data_reg      <= op_data;
                remaining_reg <= op_gens;
                forever_reg   <= (op_gens == '0);
                period_reg    <= period;
                wait_cnt_reg  <= '0;
            end
            case (state_reg)
                CLEAR:   gen_count_reg <= '0;
                CAPTURE: rd_data_reg   <= pe_state_i;
                WAIT:    wait_cnt_reg  <= wait_last ? '0 : wait_cnt_reg + PERIOD_W'(1);
                STEP: begin
                    gen_count_reg <= gen_count_reg + GEN_W'(1);
                    if (!forever_reg)
                        remaining_reg <= remaining_reg - GEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
